// File: rtl/gpu_depth_pkg.sv
// Shared depth-test types: compare functions used by every z-buffer client and the
// sequencing states of the depth test controller.
package gpu_depth_pkg;

    typedef enum logic [2:0] {
        Z_NEVER    = 3'd0,
        Z_LESS     = 3'd1,
        Z_LEQUAL   = 3'd2,
        Z_GREATER  = 3'd3,
        Z_GEQUAL   = 3'd4,
        Z_EQUAL    = 3'd5,
        Z_NOTEQUAL = 3'd6,
        Z_ALWAYS   = 3'd7
    } z_func_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/depth_compare.sv
// Combinational depth comparison (frag_z OP stored_z, unsigned); shared with early-Z.
module depth_compare
    import gpu_depth_pkg::*;
#(
    parameter int Z_SIZE = 8
) (
    input  z_func_t           func_i,
    input  logic [Z_SIZE-1:0] frag_z_i,
    input  logic [Z_SIZE-1:0] stored_z_i,
    output logic              pass_o
);

    always_comb begin
        pass_o = 1'b0;
        case (func_i)
            Z_NEVER:    pass_o = 1'b0;
            Z_LESS:     pass_o = frag_z_i <  stored_z_i;
            Z_LEQUAL:   pass_o = frag_z_i <= stored_z_i;
            Z_GREATER:  pass_o = frag_z_i >  stored_z_i;
            Z_GEQUAL:   pass_o = frag_z_i >= stored_z_i;
            Z_EQUAL:    pass_o = frag_z_i == stored_z_i;
            Z_NOTEQUAL: pass_o = frag_z_i != stored_z_i;
            Z_ALWAYS:   pass_o = 1'b1;
            default:    pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/depth_test_ctrl.sv
// Two-stage per-fragment depth test sequencer (read / compare+write-back) with an
// arbitrated full-frame clear sweep over the depth RAM.
module depth_test_ctrl
    import gpu_depth_pkg::*;
#(
    parameter int Z_SIZE = 8,
    parameter int X_RES  = 1280,
    parameter int Y_RES  = 720,
    parameter int ADDR_W = $clog2(X_RES * Y_RES),
    localparam int X_W   = $clog2(X_RES),
    localparam int Y_W   = $clog2(Y_RES)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              depth_en_i,
    input  logic [2:0]        depth_func_i,
    input  logic              depth_wr_en_i,
    input  logic              clear_req_i,
    input  logic [Z_SIZE-1:0] clear_val_i,
    output logic              clear_busy_o,
    input  logic              frag_valid_i,
    output logic              frag_ready_o,
    input  logic [X_W-1:0]    frag_x_i,
    input  logic [Y_W-1:0]    frag_y_i,
    input  logic [Z_SIZE-1:0] frag_z_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [X_W-1:0]    out_x_o,
    output logic [Y_W-1:0]    out_y_o,
    output logic              out_pass_o,
    output logic              ram_rd_en_o,
    output logic [ADDR_W-1:0] ram_rd_addr_o,
    input  logic [Z_SIZE-1:0] ram_rd_data_i,
    output logic              ram_wr_en_o,
    output logic [ADDR_W-1:0] ram_wr_addr_o,
    output logic [Z_SIZE-1:0] ram_wr_data_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(X_RES * Y_RES - 1);
    localparam logic [X_W:0]      X_LIM     = (X_W + 1)'(X_RES);
    localparam logic [Y_W:0]      Y_LIM     = (Y_W + 1)'(Y_RES);

    ctrl_state_t       state_q;
    logic              clearBusy_q;
    logic [Z_SIZE-1:0] clearVal_q;
    logic [ADDR_W-1:0] clearAddr_q;

    logic              s2Valid_q, s2Done_q, s2Pass_q, s2Test_q, s2FixedPass_q;
    logic              s2WrEn_q, s2Fwd_q;
    z_func_t           s2Func_q;
    logic [X_W-1:0]    s2X_q;
    logic [Y_W-1:0]    s2Y_q;
    logic [Z_SIZE-1:0] s2Z_q, s2FwdZ_q;
    logic [ADDR_W-1:0] s2Addr_q;

    logic              outValid_q, outPass_q;
    logic [X_W-1:0]    outX_q;
    logic [Y_W-1:0]    outY_q;

    logic              inRange, needTest, stall, accept, fwdHit;
    logic              livePass, s2PassNow, s2Write, s2Move;
    logic [ADDR_W-1:0] fragAddr;
    logic [Z_SIZE-1:0] storedZ;

    assign inRange  = ({1'b0, frag_x_i} < X_LIM) && ({1'b0, frag_y_i} < Y_LIM);
    assign needTest = depth_en_i && inRange;
    assign fragAddr = ADDR_W'(frag_y_i) * ADDR_W'(X_RES) + ADDR_W'(frag_x_i);

    assign stall        = s2Valid_q && outValid_q && !out_ready_i;
    assign frag_ready_o = (state_q == ST_RUN) && !stall;
    assign accept       = frag_valid_i && frag_ready_o;

    assign ram_rd_en_o   = accept && needTest;
    assign ram_rd_addr_o = fragAddr;

    // A same-cycle write to the address being read is not visible in the RAM read data.
    assign storedZ = s2Fwd_q ? s2FwdZ_q : ram_rd_data_i;

    depth_compare #(.Z_SIZE(Z_SIZE)) u_compare (
        .func_i     (s2Func_q),
        .frag_z_i   (s2Z_q),
        .stored_z_i (storedZ),
        .pass_o     (livePass)
    );

    // RAM data is only valid on the first S2 cycle; a stalled S2 keeps its own verdict.
    assign s2PassNow = !s2Test_q ? s2FixedPass_q : (s2Done_q ? s2Pass_q : livePass);
    assign s2Write   = s2Valid_q && s2Test_q && !s2Done_q && livePass && s2WrEn_q;
    assign s2Move    = s2Valid_q && !stall;
    assign fwdHit    = s2Write && (s2Addr_q == fragAddr);

    assign ram_wr_en_o   = (state_q == ST_CLEAR) || s2Write;
    assign ram_wr_addr_o = (state_q == ST_CLEAR) ? clearAddr_q : s2Addr_q;
    assign ram_wr_data_o = (state_q == ST_CLEAR) ? clearVal_q : s2Z_q;

    assign clear_busy_o = clearBusy_q;
    assign out_valid_o  = outValid_q;
    assign out_x_o      = outX_q;
    assign out_y_o      = outY_q;
    assign out_pass_o   = outPass_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2Valid_q  <= 1'b0;
            s2Done_q   <= 1'b0;
            outValid_q <= 1'b0;
        end else begin
            if (s2Move) begin
                outValid_q <= 1'b1;
                outX_q     <= s2X_q;
                outY_q     <= s2Y_q;
                outPass_q  <= s2PassNow;
            end else if (out_ready_i) begin
                outValid_q <= 1'b0;
            end

            if (accept) begin
                s2Valid_q     <= 1'b1;
                s2Done_q      <= 1'b0;
                s2Test_q      <= needTest;
                s2FixedPass_q <= inRange;
                s2WrEn_q      <= depth_wr_en_i;
                s2Func_q      <= z_func_t'(depth_func_i);
                s2X_q         <= frag_x_i;
                s2Y_q         <= frag_y_i;
                s2Z_q         <= frag_z_i;
                s2Addr_q      <= fragAddr;
                s2Fwd_q       <= fwdHit;
                s2FwdZ_q      <= ram_wr_data_o;
            end else if (s2Move) begin
                s2Valid_q <= 1'b0;
            end else if (s2Valid_q) begin
                s2Done_q <= 1'b1;
                s2Pass_q <= s2PassNow;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            clearBusy_q <= 1'b0;
            clearAddr_q <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (clear_req_i) begin
                        state_q     <= ST_DRAIN;
                        clearBusy_q <= 1'b1;
                        clearVal_q  <= clear_val_i;
                    end
                end
                ST_DRAIN: begin
                    if (!s2Valid_q && !outValid_q) begin
                        state_q     <= ST_CLEAR;
                        clearAddr_q <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (clearAddr_q == LAST_ADDR) begin
                        state_q     <= ST_RUN;
                        clearBusy_q <= 1'b0;
                    end else begin
                        clearAddr_q <= clearAddr_q + ADDR_W'(1);
                    end
                end
                default: begin
                    state_q     <= ST_RUN;
                    clearBusy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_depth_test_ctrl.sv
// Directed bench for depth_test_ctrl on a 6x3 frame with a behavioural depth RAM.
module tb_depth_test_ctrl;

    localparam int Z_SIZE = 8;
    localparam int X_RES  = 6;
    localparam int Y_RES  = 3;
    localparam int NPIX   = 18;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              depthEn, depthWrEn, clearReq, clearBusy;
    logic [2:0]        depthFunc;
    logic [7:0]        clearVal;
    logic              fragValid, fragReady;
    logic [2:0]        fragX;
    logic [1:0]        fragY;
    logic [7:0]        fragZ;
    logic              outValid, outReady, outPass;
    logic [2:0]        outX;
    logic [1:0]        outY;
    logic              ramRdEn, ramWrEn;
    logic [ADDR_W-1:0] ramRdAddr, ramWrAddr;
    logic [7:0]        ramRdData, ramWrData;

    logic [7:0] mem [NPIX];
    int wrCount = 0, rdCount = 0, wr80Count = 0;
    int tests = 0, fails = 0;
    logic [2:0] gotX [$];
    bit         gotPass [$];

    always #5 clk = ~clk;

    depth_test_ctrl #(.Z_SIZE(Z_SIZE), .X_RES(X_RES), .Y_RES(Y_RES)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .depth_en_i    (depthEn),
        .depth_func_i  (depthFunc),
        .depth_wr_en_i (depthWrEn),
        .clear_req_i   (clearReq),
        .clear_val_i   (clearVal),
        .clear_busy_o  (clearBusy),
        .frag_valid_i  (fragValid),
        .frag_ready_o  (fragReady),
        .frag_x_i      (fragX),
        .frag_y_i      (fragY),
        .frag_z_i      (fragZ),
        .out_valid_o   (outValid),
        .out_ready_i   (outReady),
        .out_x_o       (outX),
        .out_y_o       (outY),
        .out_pass_o    (outPass),
        .ram_rd_en_o   (ramRdEn),
        .ram_rd_addr_o (ramRdAddr),
        .ram_rd_data_i (ramRdData),
        .ram_wr_en_o   (ramWrEn),
        .ram_wr_addr_o (ramWrAddr),
        .ram_wr_data_o (ramWrData)
    );

    // Depth RAM: registered read returning pre-write contents on a same-address collision.
    always @(posedge clk) begin
        if (ramWrEn) begin
            mem[ramWrAddr] <= ramWrData;
            wrCount++;
            if (ramWrData == 8'h80) wr80Count++;
        end
        if (ramRdEn) begin
            ramRdData <= mem[ramRdAddr];
            rdCount++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] x, input logic [1:0] y, input logic [7:0] z);
        fragX = x;
        fragY = y;
        fragZ = z;
        fragValid = 1'b1;
    endtask

    // One clock: record handshakes just before the edge, retire an accepted fragment after it.
    task automatic runCycle();
        logic acc, taken;
        #1;
        acc   = fragValid && fragReady;
        taken = outValid && outReady;
        if (taken) begin
            gotX.push_back(outX);
            gotPass.push_back(outPass);
        end
        @(posedge clk);
        #1;
        if (acc) fragValid = 1'b0;
    endtask

    task automatic sendFrag(input logic [2:0] x, input logic [1:0] y, input logic [7:0] z);
        int n;
        applyStimulus(x, y, z);
        n = 0;
        while (fragValid && n < 20) begin
            runCycle();
            n++;
        end
        checkOutput($sformatf("accept_%0d_%0d", x, y), fragValid, 1'b0);
        fragValid = 1'b0;
    endtask

    task automatic doClear(input logic [7:0] val);
        int n;
        clearVal = val;
        clearReq = 1'b1;
        runCycle();
        clearReq = 1'b0;
        n = 0;
        while (clearBusy && n < 200) begin
            runCycle();
            n++;
        end
        checkOutput("clear_len", n, NPIX + 1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int n, baseWr, baseRd, base80;
        logic [2:0] expTab [8];
        bit expPass [6];
        expTab  = '{3'b000, 3'b100, 3'b110, 3'b001, 3'b011, 3'b010, 3'b101, 3'b111};
        expPass = '{1, 1, 1, 1, 0, 0};

        rst = 1'b1; depthEn = 1'b1; depthFunc = 3'd1; depthWrEn = 1'b1;
        clearReq = 1'b0; clearVal = 8'h00; fragValid = 1'b0;
        fragX = '0; fragY = '0; fragZ = '0; outReady = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("rst_out_valid", outValid, 1'b0);
        checkOutput("rst_busy", clearBusy, 1'b0);
        checkOutput("rst_ready", fragReady, 1'b1);
        checkOutput("rst_rd_en", ramRdEn, 1'b0);
        checkOutput("rst_wr_en", ramWrEn, 1'b0);
        rst = 1'b0;

        // Test 1: clear to 255, then LESS with two back-to-back fragments on pixel (1,1).
        doClear(8'hFF);
        checkOutput("clear255_mem0", mem[0], 8'hFF);
        checkOutput("clear255_mem17", mem[17], 8'hFF);
        gotX.delete(); gotPass.delete();
        applyStimulus(3'd1, 2'd1, 8'd10);
        #1;
        checkOutput("t1_rd_en", ramRdEn, 1'b1);
        checkOutput("t1_rd_addr", ramRdAddr, 7);
        runCycle();
        applyStimulus(3'd1, 2'd1, 8'd20);
        #1;
        checkOutput("t1_wr_en", ramWrEn, 1'b1);
        checkOutput("t1_wr_addr", ramWrAddr, 7);
        checkOutput("t1_wr_data", ramWrData, 10);
        runCycle();
        checkOutput("t1_latency_valid", outValid, 1'b1);
        checkOutput("t1_first_pass", outPass, 1'b1);
        repeat (3) runCycle();
        checkOutput("t1_count", gotPass.size(), 2);
        checkOutput("t1_pass_a", gotPass[0], 1'b1);
        checkOutput("t1_pass_b_fwd", gotPass[1], 1'b0);
        checkOutput("t1_mem7", mem[7], 10);

        // Test 2: output back-pressure with three fragments queued.
        gotX.delete(); gotPass.delete();
        outReady = 1'b0;
        baseWr = wrCount;
        sendFrag(3'd0, 2'd0, 8'd5);
        sendFrag(3'd2, 2'd0, 8'd6);
        applyStimulus(3'd3, 2'd0, 8'd7);
        runCycle();
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("t2_stall_ready%0d", i), fragReady, 1'b0);
            checkOutput($sformatf("t2_stall_x%0d", i), outX, 0);
            runCycle();
        end
        checkOutput("t2_stall_writes", wrCount - baseWr, 2);
        outReady = 1'b1;
        n = 0;
        while (gotX.size() < 3 && n < 20) begin
            runCycle();
            n++;
        end
        checkOutput("t2_frag3_accepted", fragValid, 1'b0);
        checkOutput("t2_order0", gotX[0], 0);
        checkOutput("t2_order1", gotX[1], 2);
        checkOutput("t2_order2", gotX[2], 3);
        checkOutput("t2_pass2", gotPass[2], 1'b1);
        repeat (2) runCycle();
        checkOutput("t2_mem3", mem[3], 7);

        // Test 3: clear request arriving together with a fragment, one more pulse mid-sweep.
        gotX.delete(); gotPass.delete();
        base80 = wr80Count;
        sendFrag(3'd4, 2'd0, 8'd9);
        applyStimulus(3'd5, 2'd0, 8'd9);
        clearVal = 8'h80;
        clearReq = 1'b1;
        runCycle();
        clearReq = 1'b0;
        checkOutput("t3_frag_with_clear", fragValid, 1'b0);
        checkOutput("t3_busy", clearBusy, 1'b1);
        n = 0;
        while (clearBusy && n < 100) begin
            clearReq = (n == 5);
            runCycle();
            n++;
        end
        clearReq = 1'b0;
        checkOutput("t3_busy_done", clearBusy, 1'b0);
        checkOutput("t3_out_count", gotX.size(), 2);
        checkOutput("t3_out0", gotX[0], 4);
        checkOutput("t3_out1", gotX[1], 5);
        checkOutput("t3_clear_writes", wr80Count - base80, NPIX);
        checkOutput("t3_mem4", mem[4], 8'h80);
        checkOutput("t3_mem17", mem[17], 8'h80);
        repeat (3) runCycle();
        checkOutput("t3_no_second_sweep", clearBusy, 1'b0);

        // Test 4: every compare function against stored 100, with writes masked.
        doClear(8'd100);
        gotX.delete(); gotPass.delete();
        depthWrEn = 1'b0;
        baseWr = wrCount;
        for (int f = 0; f < 8; f++) begin
            depthFunc = 3'(f);
            for (int k = 0; k < 3; k++) sendFrag(3'd0, 2'd0, 8'(99 + k));
        end
        repeat (4) runCycle();
        checkOutput("t4_count", gotPass.size(), 24);
        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < 3; k++) begin
                checkOutput($sformatf("t4_func%0d_z%0d", f, 99 + k), gotPass[f * 3 + k], expTab[f][2 - k]);
            end
        end
        checkOutput("t4_no_writes", wrCount - baseWr, 0);

        // Test 5: depth test disabled, then out-of-range coordinates with the test enabled.
        gotX.delete(); gotPass.delete();
        depthEn = 1'b0; depthWrEn = 1'b1; depthFunc = 3'd0;
        baseWr = wrCount; baseRd = rdCount;
        sendFrag(3'd0, 2'd0, 8'd1);
        sendFrag(3'd1, 2'd0, 8'd200);
        sendFrag(3'd2, 2'd2, 8'd50);
        sendFrag(3'd5, 2'd2, 8'd0);
        depthEn = 1'b1; depthFunc = 3'd7;
        sendFrag(3'd6, 2'd0, 8'd10);
        sendFrag(3'd0, 2'd3, 8'd10);
        repeat (4) runCycle();
        checkOutput("t5_count", gotPass.size(), 6);
        for (int i = 0; i < 6; i++) checkOutput($sformatf("t5_pass%0d", i), gotPass[i], expPass[i]);
        checkOutput("t5_no_reads", rdCount - baseRd, 0);
        checkOutput("t5_no_writes", wrCount - baseWr, 0);

        // Test 6: reset while the sweep is writing address 5.
        clearVal = 8'h11;
        clearReq = 1'b1;
        runCycle();
        clearReq = 1'b0;
        n = 0;
        while (!(ramWrEn && ramWrAddr == 5) && n < 50) begin
            runCycle();
            n++;
        end
        checkOutput("t6_reached_addr5", ramWrAddr, 5);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("t6_busy", clearBusy, 1'b0);
        checkOutput("t6_out_valid", outValid, 1'b0);
        checkOutput("t6_ready", fragReady, 1'b1);
        checkOutput("t6_wr_en", ramWrEn, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("t6_mem5", mem[5], 8'h11);
        checkOutput("t6_mem6_untouched", mem[6], 8'd100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
